// File: rtl/sump_command_decoder.sv
// -----------------------------------------------------------------------------
// sump_command_decoder
//
// Builds SUMP host commands out of the UART receive byte stream and issues a
// single-cycle write strobe for each completed command.
//   * Short command: one opcode byte with bit7 = 0.
//   * Long command : opcode byte with bit7 = 1, followed by four data bytes,
//                    least-significant byte first.
// If a long command stalls for longer than TIMEOUT idle cycles between bytes,
// the partial command is discarded and timeoutErr pulses.
//
// Ports
//   clock       in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   rxByte[7:0] in   received byte
//   rxValid     in   one-cycle strobe qualifying rxByte
//   execute     out  one-cycle pulse, a complete command was decoded
//   opcode[7:0] out  opcode of the last executed command
//   data[31:0]  out  data of the last long command (first data byte in [7:0])
//   softReset   out  pulse for opcode 0x00
//   arm         out  pulse for opcode 0x01
//   queryId     out  pulse for opcode 0x02
//   wrDivider   out  pulse for opcode 0x80
//   wrSize      out  pulse for opcode 0x81
//   wrFlags     out  pulse for opcode 0x82
//   wrTrigger   out  pulse for opcodes 0xC0-0xCF
//   busy        out  high while a long command is partially received
//   timeoutErr  out  pulse when a partial long command is discarded
// -----------------------------------------------------------------------------
module sump_command_decoder #(
    parameter int TIMEOUT     = 65535,
    parameter int TIMER_WIDTH = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  rxByte,
    input  logic        rxValid,
    output logic        execute,
    output logic [7:0]  opcode,
    output logic [31:0] data,
    output logic        softReset,
    output logic        arm,
    output logic        queryId,
    output logic        wrDivider,
    output logic        wrSize,
    output logic        wrFlags,
    output logic        wrTrigger,
    output logic        busy,
    output logic        timeoutErr
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_EXEC = 2'd2
    } state_t;

    localparam logic [TIMER_WIDTH-1:0] TIMEOUT_CNT = TIMER_WIDTH'(TIMEOUT);

    state_t                 state_r;
    logic [7:0]             hold_op_r;
    logic [31:0]            hold_data_r;
    logic                   hold_long_r;
    logic [1:0]             count_r;
    logic [TIMER_WIDTH-1:0] timer_r;

    // Strobe vector order: {softReset, arm, queryId, wrDivider, wrSize, wrFlags, wrTrigger}.
    // Unknown opcodes map to no strobe at all.
    function automatic logic [6:0] decode_strobes(input logic [7:0] op);
        logic [6:0] stb;
        stb = 7'b000_0000;
        casez (op)
            8'h00:        stb = 7'b100_0000;
            8'h01:        stb = 7'b010_0000;
            8'h02:        stb = 7'b001_0000;
            8'h80:        stb = 7'b000_1000;
            8'h81:        stb = 7'b000_0100;
            8'h82:        stb = 7'b000_0010;
            8'b1100_????: stb = 7'b000_0001;
            default:      stb = 7'b000_0000;
        endcase
        return stb;
    endfunction

    // Command assembly FSM; all outputs are registered here.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            hold_op_r   <= 8'h00;
            hold_data_r <= 32'h0000_0000;
            hold_long_r <= 1'b0;
            count_r     <= 2'd0;
            timer_r     <= '0;
            execute     <= 1'b0;
            opcode      <= 8'h00;
            data        <= 32'h0000_0000;
            busy        <= 1'b0;
            timeoutErr  <= 1'b0;
            {softReset, arm, queryId, wrDivider, wrSize, wrFlags, wrTrigger} <= 7'b000_0000;
        end else begin
            // Pulses are low unless set below.
            execute    <= 1'b0;
            timeoutErr <= 1'b0;
            {softReset, arm, queryId, wrDivider, wrSize, wrFlags, wrTrigger} <= 7'b000_0000;

            case (state_r)
                ST_IDLE, ST_EXEC: begin
                    // Publish the command completed on the previous edge.
                    if (state_r == ST_EXEC) begin
                        execute <= 1'b1;
                        opcode  <= hold_op_r;
                        if (hold_long_r) begin
                            data <= hold_data_r;
                        end else begin
                            data <= data;
                        end
                        {softReset, arm, queryId, wrDivider, wrSize, wrFlags, wrTrigger}
                            <= decode_strobes(hold_op_r);
                    end else begin
                        execute <= 1'b0;
                    end

                    // EXEC accepts a new opcode exactly like IDLE so back-to-back
                    // bytes are never dropped.
                    if (rxValid) begin
                        hold_op_r <= rxByte;
                        if (rxByte[7]) begin
                            state_r     <= ST_DATA;
                            hold_long_r <= 1'b1;
                            count_r     <= 2'd0;
                            timer_r     <= '0;
                            busy        <= 1'b1;
                        end else begin
                            state_r     <= ST_EXEC;
                            hold_long_r <= 1'b0;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end

                ST_DATA: begin
                    // A byte arriving on the timeout cycle still wins.
                    if (rxValid) begin
                        hold_data_r[{count_r, 3'b000} +: 8] <= rxByte;
                        count_r <= count_r + 2'd1;
                        timer_r <= '0;
                        if (count_r == 2'd3) begin
                            state_r <= ST_EXEC;
                            busy    <= 1'b0;
                        end else begin
                            state_r <= ST_DATA;
                        end
                    end else if (timer_r == TIMEOUT_CNT) begin
                        state_r    <= ST_IDLE;
                        busy       <= 1'b0;
                        timeoutErr <= 1'b1;
                    end else begin
                        timer_r <= timer_r + {{(TIMER_WIDTH-1){1'b0}}, 1'b1};
                    end
                end

                default: begin
                    state_r <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sump_command_decoder.sv
// -----------------------------------------------------------------------------
// tb_sump_command_decoder
//
// Two decoders share clock, reset and byte stream: u_a (TIMEOUT=8) is checked
// every cycle against a queue-based reference model; u_b (TIMEOUT=4) is used
// for the byte-versus-timeout boundary. A table of commands, hand-written
// corner sequences and a random byte stream drive the inputs.
// -----------------------------------------------------------------------------
module tb_sump_command_decoder;

    localparam int TO_A = 8;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [7:0]  rx_byte;
    logic        rx_valid;

    logic        a_execute, a_soft, a_arm, a_query, a_div, a_size, a_flags, a_trig, a_busy, a_to;
    logic [7:0]  a_opcode;
    logic [31:0] a_data;
    logic        b_execute, b_soft, b_arm, b_query, b_div, b_size, b_flags, b_trig, b_busy, b_to;
    logic [7:0]  b_opcode;
    logic [31:0] b_data;
    logic [6:0]  a_stb, b_stb;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    assign a_stb = {a_soft, a_arm, a_query, a_div, a_size, a_flags, a_trig};
    assign b_stb = {b_soft, b_arm, b_query, b_div, b_size, b_flags, b_trig};

    sump_command_decoder #(.TIMEOUT(8), .TIMER_WIDTH(4)) u_a (
        .clock(clock), .reset_n(reset_n), .rxByte(rx_byte), .rxValid(rx_valid),
        .execute(a_execute), .opcode(a_opcode), .data(a_data),
        .softReset(a_soft), .arm(a_arm), .queryId(a_query), .wrDivider(a_div),
        .wrSize(a_size), .wrFlags(a_flags), .wrTrigger(a_trig),
        .busy(a_busy), .timeoutErr(a_to)
    );

    sump_command_decoder #(.TIMEOUT(4), .TIMER_WIDTH(3)) u_b (
        .clock(clock), .reset_n(reset_n), .rxByte(rx_byte), .rxValid(rx_valid),
        .execute(b_execute), .opcode(b_opcode), .data(b_data),
        .softReset(b_soft), .arm(b_arm), .queryId(b_query), .wrDivider(b_div),
        .wrSize(b_size), .wrFlags(b_flags), .wrTrigger(b_trig),
        .busy(b_busy), .timeoutErr(b_to)
    );

    // Expected strobe for an opcode: {soft, arm, query, div, size, flags, trig}.
    function automatic logic [6:0] strobe_of(input logic [7:0] op);
        if (op == 8'h00)            return 7'b100_0000;
        else if (op == 8'h01)       return 7'b010_0000;
        else if (op == 8'h02)       return 7'b001_0000;
        else if (op == 8'h80)       return 7'b000_1000;
        else if (op == 8'h81)       return 7'b000_0100;
        else if (op == 8'h82)       return 7'b000_0010;
        else if (op[7:4] == 4'hC)   return 7'b000_0001;
        else                        return 7'b000_0000;
    endfunction

    // Reference model: bytes of an unfinished long command sit in a queue.
    logic [7:0]  cmd_q[$];
    int          idle_n;
    bit          pend, pend_long;
    logic [7:0]  pend_op;
    logic [31:0] pend_data;
    logic        m_exec, m_to, m_busy;
    logic [7:0]  m_op;
    logic [31:0] m_data;
    logic [6:0]  m_stb;

    int cnt_exec, cnt_to, cnt_soft, cnt_arm, cnt_query, cnt_div, cnt_size;
    int b_exec_n, b_to_n;

    task automatic model_reset();
        cmd_q.delete();
        idle_n = 0; pend = 1'b0; pend_long = 1'b0;
        m_exec = 1'b0; m_to = 1'b0; m_busy = 1'b0;
        m_op = 8'h00; m_data = 32'h0; m_stb = 7'h0;
    endtask

    // Outputs visible after one clock edge that sampled (v, b).
    task automatic model_step(input logic v, input logic [7:0] b);
        m_exec = 1'b0; m_to = 1'b0; m_stb = 7'h0;
        if (pend) begin
            m_exec = 1'b1;
            m_op   = pend_op;
            if (pend_long) m_data = pend_data;
            m_stb  = strobe_of(pend_op);
            pend   = 1'b0;
        end
        if (cmd_q.size() != 0) begin
            if (v) begin
                cmd_q.push_back(b);
                idle_n = 0;
                if (cmd_q.size() == 5) begin
                    pend = 1'b1; pend_long = 1'b1; pend_op = cmd_q[0];
                    pend_data = {cmd_q[4], cmd_q[3], cmd_q[2], cmd_q[1]};
                    cmd_q.delete();
                end
            end else if (idle_n == TO_A) begin
                cmd_q.delete();
                m_to = 1'b1;
            end else begin
                idle_n++;
            end
        end else if (v) begin
            if (!b[7]) begin
                pend = 1'b1; pend_long = 1'b0; pend_op = b;
            end else begin
                cmd_q.push_back(b);
                idle_n = 0;
            end
        end
        m_busy = (cmd_q.size() != 0);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clr_counts();
        cnt_exec = 0; cnt_to = 0; cnt_soft = 0; cnt_arm = 0; cnt_query = 0;
        cnt_div = 0; cnt_size = 0; b_exec_n = 0; b_to_n = 0;
    endtask

    // One clock: drive at negedge, model on posedge, compare at next negedge.
    task automatic cycle(input logic v, input logic [7:0] b);
        rx_valid = v;
        rx_byte  = b;
        @(posedge clock);
        model_step(v, b);
        @(negedge clock);
        check("cycle", {a_execute, a_opcode, a_data, a_stb, a_busy, a_to},
                       {m_exec, m_op, m_data, m_stb, m_busy, m_to});
        cnt_exec += int'(a_execute); cnt_to += int'(a_to); cnt_soft += int'(a_soft);
        cnt_arm += int'(a_arm); cnt_query += int'(a_query); cnt_div += int'(a_div);
        cnt_size += int'(a_size);
        b_exec_n += int'(b_execute); b_to_n += int'(b_to);
    endtask

    // Assert reset mid-cycle (called at a negedge), check, release at next negedge.
    task automatic do_reset();
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        #1 reset_n = 1'b0;
        #1;
        model_reset();
        check("reset_a", {a_execute, a_opcode, a_data, a_stb, a_busy, a_to}, 64'h0);
        check("reset_b", {b_execute, b_opcode, b_data, b_stb, b_busy, b_to}, 64'h0);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Sends a command with one idle cycle between its bytes.
    task automatic send(input logic [39:0] bytes, input int n);
        for (int k = 0; k < n; k++) begin
            cycle(1'b1, bytes[8*k +: 8]);
            if (k != n - 1) cycle(1'b0, 8'h00);
        end
    endtask

    typedef struct {
        logic [39:0] bytes;   // byte k in [8k+7:8k]
        int          n;
        logic [7:0]  op;
        logic [31:0] dat;
        logic [6:0]  stb;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [7:0] pick;
        int         gap;

        tbl[0] = '{40'h00_0000_0001, 1, 8'h01, 32'h0000_0000, 7'b010_0000};
        tbl[1] = '{40'h00_0000_C182, 5, 8'h82, 32'h0000_00C1, 7'b000_0010};
        tbl[2] = '{40'h44_3322_11C5, 5, 8'hC5, 32'h4433_2211, 7'b000_0001};
        tbl[3] = '{40'h00_0000_0002, 1, 8'h02, 32'h4433_2211, 7'b001_0000};
        tbl[4] = '{40'h12_3456_7880, 5, 8'h80, 32'h1234_5678, 7'b000_1000};
        tbl[5] = '{40'h00_0000_0000, 1, 8'h00, 32'h1234_5678, 7'b100_0000};
        tbl[6] = '{40'h00_0000_0081, 5, 8'h81, 32'h0000_0000, 7'b000_0100};
        tbl[7] = '{40'h00_0000_0005, 1, 8'h05, 32'h0000_0000, 7'b000_0000};
        tbl[8] = '{40'hDD_CCBB_AA93, 5, 8'h93, 32'hDDCC_BBAA, 7'b000_0000};
        tbl[9] = '{40'h04_0302_01CF, 5, 8'hCF, 32'h0403_0201, 7'b000_0001};

        reset_n  = 1'b0;
        rx_valid = 1'b0;
        rx_byte  = 8'h00;
        model_reset();
        clr_counts();
        @(negedge clock);
        do_reset();

        // Table: execute must be high exactly one cycle, two cycles after the last byte.
        for (int i = 0; i < 10; i++) begin
            send(tbl[i].bytes, tbl[i].n);
            cycle(1'b0, 8'h00);
            check("vec_exec",   a_execute, 1'b1);
            check("vec_opcode", a_opcode,  tbl[i].op);
            check("vec_data",   a_data,    tbl[i].dat);
            check("vec_strobe", a_stb,     tbl[i].stb);
            cycle(1'b0, 8'h00);
            check("vec_pulse_end", a_execute, 1'b0);
        end

        // Stalled long command is flushed by the timeout; data is preserved.
        clr_counts();
        send(40'h10_80, 2);
        repeat (10) cycle(1'b0, 8'h00);
        check("to_pulses", cnt_to, 1);
        check("to_no_exec", cnt_exec, 0);
        send(40'h02, 1);
        cycle(1'b0, 8'h00);
        check("to_query", a_query, 1'b1);
        check("to_data_held", a_data, 32'h0403_0201);
        cycle(1'b0, 8'h00);

        // Host reset sequence, then a zero-valued size write.
        clr_counts();
        repeat (5) begin
            cycle(1'b1, 8'h00);
            repeat (9) cycle(1'b0, 8'h00);
        end
        check("soft_pulses", cnt_soft, 5);
        send(40'h00_0000_0081, 5);
        cycle(1'b0, 8'h00);
        check("size_exec", a_size, 1'b1);
        check("size_data", a_data, 32'h0);
        cycle(1'b0, 8'h00);

        // Reset during a long command drops it.
        send(40'h22_11_80, 3);
        cycle(1'b0, 8'h00);
        check("mid_busy", a_busy, 1'b1);
        do_reset();
        clr_counts();
        send(40'h01, 1);
        repeat (3) cycle(1'b0, 8'h00);
        check("post_rst_arm", cnt_arm, 1);
        check("post_rst_div", cnt_div, 0);

        // TIMEOUT=4 decoder: fourth data byte lands when its timer equals 4.
        do_reset();
        clr_counts();
        send(40'h33_2211_C0, 4);
        repeat (4) cycle(1'b0, 8'h00);
        cycle(1'b1, 8'h44);
        cycle(1'b0, 8'h00);
        check("b_edge_exec", b_execute, 1'b1);
        check("b_edge_data", b_data, 32'h4433_2211);
        check("b_edge_trig", b_trig, 1'b1);
        cycle(1'b0, 8'h00);
        check("b_edge_no_to", b_to_n, 0);
        // One more idle cycle than that and the command is lost.
        clr_counts();
        send(40'h03_0201_C3, 4);
        repeat (6) cycle(1'b0, 8'h00);
        check("b_late_to", b_to_n, 1);
        check("b_late_no_exec", b_exec_n, 0);

        // Random stream with varying gaps (including back-to-back bytes).
        for (int r = 0; r < 400; r++) begin
            gap = int'($urandom_range(0, 11));
            repeat (gap) cycle(1'b0, 8'h00);
            case ($urandom_range(0, 3))
                0:       pick = 8'($urandom);
                1:       pick = 8'($urandom_range(0, 3));
                2:       pick = 8'h80 + 8'($urandom_range(0, 2));
                default: pick = 8'hC0 | 8'($urandom_range(0, 15));
            endcase
            cycle(1'b1, pick);
        end
        repeat (12) cycle(1'b0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sump_command_decoder.md
Name: sump_command_decoder

Overview:
- Assembles SUMP host commands from the UART receive byte stream and issues single-cycle write strobes to the configuration registers: flags register, sample-rate divider, capture size and trigger stages.
- Sits between the UART receiver and the configuration/control logic, all in the system clock domain.
- Short commands are 1 byte (opcode bit7=0). Long commands are 5 bytes: opcode (bit7=1) followed by 4 data bytes, least-significant byte first.

Parameters:
- TIMEOUT, 65535, idle cycles allowed between bytes of a long command before the partial command is discarded (must be ≥1).
- TIMER_WIDTH, 16, width of the inter-byte timeout counter (must hold TIMEOUT).

Ports:
- clock  input  1  system clock; all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- rxByte  input  8  received byte from UART
- rxValid  input  1  one-cycle strobe; rxByte valid this cycle
- execute  output  1  one-cycle pulse; a complete command is decoded
- opcode  output  8  opcode of the last executed command
- data  output  32  data of the last long command; first data byte in [7:0]
- softReset  output  1  pulse, opcode 0x00
- arm  output  1  pulse, opcode 0x01
- queryId  output  1  pulse, opcode 0x02
- wrDivider  output  1  pulse, opcode 0x80
- wrSize  output  1  pulse, opcode 0x81
- wrFlags  output  1  pulse, opcode 0x82; flags register takes data[7:0]
- wrTrigger  output  1  pulse, opcodes 0xC0–0xCF; opcode[3:2]=stage, opcode[1:0]=register
- busy  output  1  high while a long command is partially received
- timeoutErr  output  1  pulse when a partial command is discarded

Behaviour:
- Reset (async, reset_n=0): state IDLE, byte count 0, timer 0.
  - opcode=0x00, data=0x00000000, busy=0.
  - All strobes, execute and timeoutErr are 0.
- State IDLE, on rxValid:
  - Latch rxByte into the opcode holding register.
  - If bit7=0: go to EXEC.
  - If bit7=1: go to DATA, count=0, timer=0, busy=1.
- State DATA, on rxValid:
  - Shift rxByte into holding byte[count]; count increments and timer clears.
  - After byte count=3: go to EXEC, busy=0.
- State DATA, no rxValid: timer increments.
  - When timer reaches TIMEOUT: return to IDLE, busy=0, timeoutErr pulses 1 cycle.
  - Holding registers are discarded; opcode/data outputs are unchanged.
- Simultaneous rxValid and timer==TIMEOUT in DATA: the byte wins. It is accepted, the timer clears and no timeout occurs.
- State EXEC (1 cycle): go to IDLE.
  - The execute pulse and the decoded strobe are registered outputs. They are high in the cycle after EXEC is entered.
  - opcode/data outputs update in that same cycle.
  - Short command: data output holds its previous value.
- Latency, short command: execute is high 2 cycles after the rxValid of the opcode.
- Latency, long command: execute is high 2 cycles after the rxValid of the 4th data byte.
- rxValid during the EXEC cycle: the byte is treated as a new opcode, exactly as in IDLE, so no byte is lost. UART byte spacing guarantees ≥2 cycles between bytes, but the decoder does not rely on it.
- Exactly one of the 7 strobes accompanies execute for known opcodes.
- Unknown opcodes: execute pulses, opcode/data update, no strobe.
- Host reset sequence (five 0x00 bytes) yields five softReset pulses. Any partially received long command is flushed by the timeout, not by 0x00 bytes. Bytes 0x00 inside DATA are data.
- Reset asserted mid-command: immediate return to IDLE with all outputs at reset values. No strobe is emitted for the interrupted command.
- Strobes never assert while reset_n=0 nor in the cycle reset_n deasserts.

Test Plan:
- Byte 0x01 → arm=1 and execute=1 for exactly one cycle, 2 cycles after rxValid; opcode=0x01; data unchanged; busy stays 0.
- Bytes 0x82,0xC1,0x00,0x00,0x00 → wrFlags pulse; data=0x000000C1; opcode=0x82; busy=1 from the first byte until EXEC, then 0.
- Bytes 0xC5,0x11,0x22,0x33,0x44 → wrTrigger pulse; data=0x44332211; opcode[3:2]=1, [1:0]=1.
- Bytes 0x80,0x10 then 10 idle cycles, with TIMEOUT=8 → timeoutErr pulse, no execute. Then 0x02 → queryId pulse; data holds its prior value.
- Five 0x00 bytes spaced 10 cycles → exactly 5 softReset pulses. Then 0x81,0x00,0x00,0x00,0x00 → wrSize with data=0x00000000.
- reset_n=0 after the 2nd data byte of 0x80 → busy=0, outputs zeroed. After release, 0x01 → arm only, no wrDivider.
- Additional case with TIMEOUT=4: 4th data byte arriving on the cycle timer==4 → command completes, no timeoutErr.
